// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: packet deframer behind the UART receive FIFO.
//
// Pops bytes from the RX FIFO whenever one is available and parses each
// frame in the form SYNC, LEN, PAYLOAD[LEN], CSUM.
//   - Payload bytes are streamed out cut-through, before the frame is validated.
//   - Each frame ends with either a pkt_done pulse or a pkt_err pulse.
//   - An inter-byte idle timeout aborts truncated frames.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rx_empty   UART RX FIFO empty flag
//   r_data     UART RX FIFO head byte, valid while rx_empty=0
//   rd_uart    pop strobe to the FIFO (combinational, always ready)
//   pkt_start  pulse: a valid length byte was accepted
//   out_data   payload byte
//   out_valid  pulse qualifying out_data
//   pkt_done   pulse: the frame passed its checksum
//   pkt_err    pulse: the frame was aborted
//   err_code   cause of the last abort (01 length, 10 checksum, 11 timeout)
//   pkt_len    length of the current or last accepted frame
//   drop_cnt   saturating count of non-sync bytes discarded while hunting
module uart_pkt_rx #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TO_W    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic       pkt_start,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic [7:0] pkt_len,
    output logic [7:0] drop_cnt
);

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    // The counter reaching TIMEOUT is detected one increment early.
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      acc;
    logic [7:0]      remaining;
    logic [TO_W-1:0] to_cnt;
    logic            take;

    // The block never stalls, so every available byte is popped.
    assign rd_uart = ~rx_empty & reset_n;
    assign take    = rd_uart;

    // Frame parser, timeout and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            acc       <= 8'd0;
            remaining <= 8'd0;
            to_cnt    <= '0;
            pkt_start <= 1'b0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= 2'b00;
            pkt_len   <= 8'd0;
            drop_cnt  <= 8'd0;
        end else begin
            pkt_start <= 1'b0;
            out_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;

            // Idle timeout inside a frame; a byte present this cycle wins.
            if (state == HUNT || take) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt   <= '0;
                pkt_err  <= 1'b1;
                err_code <= ERR_TO;
                state    <= HUNT;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (take) begin
                unique case (state)
                    HUNT: begin
                        if (r_data == SYNC) begin
                            acc   <= 8'd0;
                            state <= LEN;
                        end else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                    LEN: begin
                        if (r_data == 8'd0 || r_data > MAX_LEN_B) begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_LEN;
                            state    <= HUNT;
                        end else begin
                            pkt_len   <= r_data;
                            remaining <= r_data;
                            acc       <= r_data;
                            pkt_start <= 1'b1;
                            state     <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        out_data  <= r_data;
                        out_valid <= 1'b1;
                        acc       <= acc + r_data;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (8'(acc + r_data) == 8'd0) begin
                            pkt_done <= 1'b1;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx with a short timeout (TIMEOUT=100).
// Inputs change on the falling edge.
// Outputs are sampled 1 time unit after the rising edge that takes a byte.
module tb_uart_pkt_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       pkt_start;
    logic [7:0] out_data;
    logic       out_valid;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [7:0] pkt_len;
    logic [7:0] drop_cnt;

    int passed = 0;
    int total  = 0;

    uart_pkt_rx #(
        .SYNC    (8'hA5),
        .MAX_LEN (64),
        .TIMEOUT (100),
        .TO_W    (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .pkt_start (pkt_start),
        .out_data  (out_data),
        .out_valid (out_valid),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .pkt_len   (pkt_len),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Packed pulse flags: {pkt_start, out_valid, pkt_done, pkt_err}.
    function automatic logic [31:0] pulses();
        return 32'({pkt_start, out_valid, pkt_done, pkt_err});
    endfunction

    // One clock cycle: present (empty, data), then sample just after the edge.
    task automatic cyc(input logic e, input logic [7:0] d);
        @(negedge clk);
        rx_empty = e;
        r_data   = d;
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        reset_n  = 1'b0;
        rx_empty = 1'b0;
        r_data   = 8'hA5;
        #12;
        chk("reset_rd_uart", 32'(rd_uart), 0);
        chk("reset_pulses", pulses(), 0);
        chk("reset_regs", {8'd0, out_data, pkt_len, drop_cnt}, 0);
        chk("reset_err_code", 32'(err_code), 0);
        @(negedge clk);
        rx_empty = 1'b1;
        reset_n  = 1'b1;

        // Good frame: len 3, payload 11 22 33; checksum 0x97 since 03+11+22+33 = 0x69.
        cyc(0, 8'hA5); chk("f1_sync", pulses(), 0);
        cyc(0, 8'h03); chk("f1_start", pulses(), 4'b1000); chk("f1_len", 32'(pkt_len), 3);
        cyc(0, 8'h11); chk("f1_v0", {pulses(), 8'(out_data)}, {4'b0100, 8'h11});
        cyc(0, 8'h22); chk("f1_v1", {pulses(), 8'(out_data)}, {4'b0100, 8'h22});
        cyc(0, 8'h33); chk("f1_v2", {pulses(), 8'(out_data)}, {4'b0100, 8'h33});
        cyc(0, 8'h97); chk("f1_done", pulses(), 4'b0010); chk("f1_drop", 32'(drop_cnt), 0);
        cyc(1, 8'h00); chk("f1_idle", pulses(), 0);

        // Same frame, bad checksum.
        cyc(0, 8'hA5); cyc(0, 8'h03);
        cyc(0, 8'h11); chk("f2_v0", pulses(), 4'b0100);
        cyc(0, 8'h22); chk("f2_v1", pulses(), 4'b0100);
        cyc(0, 8'h33); chk("f2_v2", pulses(), 4'b0100);
        cyc(0, 8'h98); chk("f2_err", pulses(), 4'b0001); chk("f2_code", 32'(err_code), 2);

        // Back-to-back frame: 01 + FF + 00 wraps to 0.
        cyc(0, 8'hA5); chk("f3_sync", pulses(), 0);
        cyc(0, 8'h01); chk("f3_start", pulses(), 4'b1000);
        cyc(0, 8'hFF); chk("f3_v", {pulses(), 8'(out_data)}, {4'b0100, 8'hFF});
        cyc(0, 8'h00); chk("f3_done", pulses(), 4'b0010); chk("f3_code_hold", 32'(err_code), 2);

        // Hunting drops plus zero and oversize length bytes.
        cyc(0, 8'h00); cyc(0, 8'h5A); chk("drop2", 32'(drop_cnt), 2);
        cyc(0, 8'hA5); chk("bl0_sync", pulses(), 0);
        cyc(0, 8'h00); chk("bl0_err", pulses(), 4'b0001); chk("bl0_code", 32'(err_code), 1);
        cyc(0, 8'hA5); cyc(0, 8'h41); chk("bl65_err", pulses(), 4'b0001);
        chk("bl65_code", 32'(err_code), 1);
        chk("bl_len_hold", 32'(pkt_len), 1);
        chk("bl_drop", 32'(drop_cnt), 2);

        // MAX_LEN boundary: 64 zero bytes, checksum 0xC0.
        cyc(0, 8'hA5); cyc(0, 8'h40); chk("max_start", pulses(), 4'b1000);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(0, 8'h00);
            if (out_valid) n++;
        end
        chk("max_valid_cnt", 32'(n), 64);
        cyc(0, 8'hC0); chk("max_done", pulses(), 4'b0010); chk("max_len", 32'(pkt_len), 64);

        // Timeout: 99 idle cycles pass quietly, the 100th aborts.
        cyc(0, 8'hA5); cyc(0, 8'h02); cyc(0, 8'h10);
        n = 0;
        for (int i = 0; i < 99; i++) begin
            cyc(1, 8'h00);
            if (pkt_err) n++;
        end
        chk("to_quiet", 32'(n), 0);
        cyc(1, 8'h00); chk("to_err", pulses(), 4'b0001); chk("to_code", 32'(err_code), 3);
        cyc(1, 8'h00); chk("to_after", pulses(), 0);

        // A byte present when the counter would expire is taken instead.
        cyc(0, 8'hA5); cyc(0, 8'h02); cyc(0, 8'h10);
        n = 0;
        for (int i = 0; i < 99; i++) begin
            cyc(1, 8'h00);
            if (pkt_err) n++;
        end
        chk("edge_quiet", 32'(n), 0);
        cyc(0, 8'h20); chk("edge_v", {pulses(), 8'(out_data)}, {4'b0100, 8'h20});
        cyc(0, 8'hCE); chk("edge_done", pulses(), 4'b0010);

        // Reset mid-payload clears outputs asynchronously.
        cyc(0, 8'hA5); cyc(0, 8'h03);
        cyc(0, 8'h11); chk("mr_v", pulses(), 4'b0100);
        @(negedge clk);
        rx_empty = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mr_pulses", pulses(), 0);
        chk("mr_regs", {8'd0, out_data, pkt_len, drop_cnt}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 8'hA5); cyc(0, 8'h01); chk("mr_start", pulses(), 4'b1000);
        cyc(0, 8'hA5); chk("mr_data", {pulses(), 8'(out_data)}, {4'b0100, 8'hA5});
        cyc(0, 8'h5A); chk("mr_done", pulses(), 4'b0010);

        // Drop counter saturation.
        for (int i = 0; i < 254; i++) cyc(0, 8'h00);
        chk("drop254", 32'(drop_cnt), 254);
        for (int i = 0; i < 46; i++) cyc(0, 8'h00);
        chk("drop_sat", 32'(drop_cnt), 255);
        cyc(1, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
